stream_packer: RTL and testbench

- Successor to the fixed-width lane mux.
- Compacts a sparse set of valid input lanes (lane 0 first) and appends them to a packing accumulator.
- Emits full OUT_LANES-wide words on a valid/ready output stream.
- Adds generalised lane/word ratios, packet termination with a partial-word keep mask, and backpressure-safe occupancy tracking.
- Sits between the rANS symbol/byte emitters and the AXI-stream DMA writer.

---
 rtl/stream_packer_if.sv | 31 +++
 rtl/stream_packer.sv | 186 ++++++++++++++++++
 tb/tb_stream_packer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/stream_packer_if.sv
// Input beat stream and output word stream of the lane packer.
// Named from the packer's side: *_i are driven upstream/downstream, *_o by the packer.
interface stream_packer_if #(
  parameter int NUM_LANES  = 8,
  parameter int LANE_WIDTH = 8,
  parameter int OUT_LANES  = 8
);
  localparam int IN_WIDTH  = NUM_LANES * LANE_WIDTH;
  localparam int OUT_WIDTH = OUT_LANES * LANE_WIDTH;

  logic [NUM_LANES-1:0] valid_i;
  logic [IN_WIDTH-1:0]  data_i;
  logic                 last_i;
  logic                 ready_o;

  logic                 valid_o;
  logic                 ready_i;
  logic [OUT_WIDTH-1:0] data_o;
  logic [OUT_LANES-1:0] keep_o;
  logic                 last_o;

  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, keep_o, last_o
  );

  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, keep_o, last_o
  );
endinterface

// File: rtl/stream_packer.sv
// Compacts sparse valid lanes into OUT_LANES-wide words; last_i closes a packet with a partial-keep word.
// Latency: a beat completing a word at edge N is presented after edge N+1.
// Backpressure: ready_o drops when the accumulator cannot take a full beat; STREAM_PACKER_TIMEOUT_EN adds idle auto-flush.
module stream_packer #(
  parameter int NUM_LANES      = 8,
  parameter int LANE_WIDTH     = 8,
  parameter int OUT_LANES      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic            clk_i,
  input logic            rst_ni,
  stream_packer_if.slave bus
);

  localparam int ACC_DEPTH = 2 * OUT_LANES + NUM_LANES;
  localparam int FW        = $clog2(ACC_DEPTH + 1);
  localparam int IN_WIDTH  = NUM_LANES * LANE_WIDTH;
  localparam int OUT_WIDTH = OUT_LANES * LANE_WIDTH;
  localparam int ACC_WIDTH = ACC_DEPTH * LANE_WIDTH;

  localparam logic [FW-1:0] OUT_LANES_F = FW'(OUT_LANES);
  localparam logic [FW:0]   NUM_LANES_W = (FW+1)'(NUM_LANES);
  localparam logic [FW:0]   ACC_DEPTH_W = (FW+1)'(ACC_DEPTH);

  if (NUM_LANES < 1 || OUT_LANES < 1 || LANE_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("stream_packer: NUM_LANES, OUT_LANES, LANE_WIDTH and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  logic                 out_vld_q;
  logic [OUT_WIDTH-1:0] out_dat_q;
  logic [OUT_LANES-1:0] out_keep_q;
  logic                 out_last_q;

  logic [IN_WIDTH-1:0]  packed_dat;
  logic [FW-1:0]        pop_cnt;
  logic [OUT_LANES-1:0] keep_w;
  logic [FW-1:0]        drain_amt;
  logic [FW-1:0]        rem_fill;
  logic                 out_free;
  logic                 drain;
  logic                 term;
  logic                 in_rdy;
  logic                 beat;
  logic                 timeout_hit;
  logic                 auto_flush;

  // Prefix-count mux: valid lanes land back to back, lane 0 first.
  always_comb begin
    int cnt;
    packed_dat = '0;
    cnt        = 0;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (bus.valid_i[j]) begin
        packed_dat[cnt*LANE_WIDTH +: LANE_WIDTH] = bus.data_i[j*LANE_WIDTH +: LANE_WIDTH];
        cnt = cnt + 1;
      end
    end
    pop_cnt = FW'(cnt);
  end

  always_comb begin
    out_free  = !out_vld_q || bus.ready_i;
    drain     = out_free && ((fill_q >= OUT_LANES_F) || (state_q == ST_FLUSH));
    term      = (state_q == ST_FLUSH) && (fill_q <= OUT_LANES_F);
    drain_amt = '0;
    if (drain) begin
      drain_amt = (fill_q < OUT_LANES_F) ? fill_q : OUT_LANES_F;
    end
    rem_fill = fill_q - drain_amt;
    in_rdy   = (state_q == ST_RUN) && (({1'b0, rem_fill} + NUM_LANES_W) <= ACC_DEPTH_W);
    beat     = in_rdy && ((|bus.valid_i) || bus.last_i);
  end

  // Lanes at or above fill_q are always zero, so a short terminating word
  // comes out of the low lanes already zero-padded.
  always_comb begin
    for (int i = 0; i < OUT_LANES; i++) begin
      keep_w[i] = (i < int'(fill_q));
    end
  end

  always_comb begin
    acc_d  = acc_q;
    fill_d = rem_fill;
    if (drain) begin
      acc_d = acc_q >> (int'(drain_amt) * LANE_WIDTH);
    end
    if (beat) begin
      acc_d  = acc_d | (ACC_WIDTH'(packed_dat) << (int'(rem_fill) * LANE_WIDTH));
      fill_d = rem_fill + pop_cnt;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (beat && bus.last_i) begin
          state_d = ST_FLUSH;
        end else if (timeout_hit && !beat) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (drain && term) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

`ifdef STREAM_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_q;
  logic          auto_flush_q;

  assign timeout_hit = (state_q == ST_RUN) && (fill_q != '0) && (idle_q == TIMEOUT_T);
  assign auto_flush  = auto_flush_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q       <= '0;
      auto_flush_q <= 1'b0;
    end else begin
      if (beat || (fill_q == '0) || (state_q != ST_RUN)) begin
        idle_q <= '0;
      end else if (!timeout_hit) begin
        idle_q <= idle_q + TW'(1);
      end
      // A flush entered without a beat came from the idle timer, so its last word is not a packet end.
      if ((state_q == ST_RUN) && (state_d == ST_FLUSH)) begin
        auto_flush_q <= !beat;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign auto_flush  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      fill_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else if (drain) begin
      out_vld_q  <= 1'b1;
      out_dat_q  <= acc_q[OUT_WIDTH-1:0];
      out_keep_q <= keep_w;
      out_last_q <= term && !auto_flush;
    end else if (bus.ready_i) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign bus.ready_o = in_rdy;
  assign bus.valid_o = out_vld_q;
  assign bus.data_o  = out_dat_q;
  assign bus.keep_o  = out_keep_q;
  assign bus.last_o  = out_last_q;

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer with 8 lanes in, 8 lanes out, 8-bit lanes.
module tb_stream_packer;
  localparam int NL = 8;
  localparam int LW = 8;
  localparam int OL = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_packer_if #(.NUM_LANES(NL), .LANE_WIDTH(LW), .OUT_LANES(OL)) bus ();

  stream_packer #(
    .NUM_LANES(NL), .LANE_WIDTH(LW), .OUT_LANES(OL), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] v, input logic [63:0] d, input logic l);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.last_i  = l;
  endtask

  function automatic logic [63:0] lanes(input int base);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(base + j);
    return w;
  endfunction

  bit [9:0] exp_rdy;

  initial begin
    exp_rdy = 10'b00_0000_1111;
    drive(8'h00, 64'h0, 1'b0);
    bus.ready_i = 1'b1;
    repeat (2) tick();
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_last",  64'(bus.last_o),  64'd0);
    chk("rst_keep",  64'(bus.keep_o),  64'd0);
    chk("rst_data",  bus.data_o,       64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(bus.ready_o), 64'd1);

    // full beat -> one word one cycle later
    drive(8'hFF, 64'h0706050403020100, 1'b0);
    tick();
    drive(8'h00, 64'h0, 1'b0);
    chk("t1_latency", 64'(bus.valid_o), 64'd0);
    tick();
    chk("t1_valid", 64'(bus.valid_o), 64'd1);
    chk("t1_data",  bus.data_o, 64'h0706050403020100);
    chk("t1_keep",  64'(bus.keep_o), 64'hFF);
    chk("t1_last",  64'(bus.last_o), 64'd0);

    // sparse compaction
    drive(8'hA5, 64'h1716151413121110, 1'b0);
    tick();
    drive(8'h0F, lanes(8'h20), 1'b0);
    tick();
    drive(8'h00, 64'h0, 1'b0);
    tick();
    chk("t2_valid", 64'(bus.valid_o), 64'd1);
    chk("t2_data",  bus.data_o, 64'h2322212017151210);
    chk("t2_keep",  64'(bus.keep_o), 64'hFF);
    tick();
    chk("t2_gone", 64'(bus.valid_o), 64'd0);

    // stalled output with continuous full beats
    bus.ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(8'hFF, lanes(8'h40 + 8*c), 1'b0);
      chk($sformatf("t3_ready_%0d", c), 64'(bus.ready_o), 64'(exp_rdy[c]));
      tick();
    end
    drive(8'h00, 64'h0, 1'b0);
    bus.ready_i = 1'b1;
    chk("t3_held_valid", 64'(bus.valid_o), 64'd1);
    chk("t3_word0", bus.data_o, lanes(8'h40));
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("t3_valid%0d", i), 64'(bus.valid_o), 64'd1);
      chk($sformatf("t3_word%0d", i), bus.data_o, lanes(8'h40 + 8*i));
    end
    tick();
    chk("t3_drained", 64'(bus.valid_o), 64'd0);

    // short packet
    drive(8'h07, 64'h0000000000CCBBAA, 1'b1);
    chk("t4_ready_in", 64'(bus.ready_o), 64'd1);
    tick();
    drive(8'h00, 64'h0, 1'b0);
    chk("t4_ready_flush", 64'(bus.ready_o), 64'd0);
    chk("t4_not_yet", 64'(bus.valid_o), 64'd0);
    tick();
    chk("t4_valid", 64'(bus.valid_o), 64'd1);
    chk("t4_data",  bus.data_o, 64'h0000000000CCBBAA);
    chk("t4_keep",  64'(bus.keep_o), 64'h07);
    chk("t4_last",  64'(bus.last_o), 64'd1);
    chk("t4_ready_back", 64'(bus.ready_o), 64'd1);

    // exact two-word packet, then empty packet
    drive(8'hFF, lanes(8'h60), 1'b0);
    tick();
    drive(8'hFF, lanes(8'h68), 1'b1);
    tick();
    drive(8'h00, 64'h0, 1'b0);
    chk("t5_w0_data", bus.data_o, lanes(8'h60));
    chk("t5_w0_last", 64'(bus.last_o), 64'd0);
    chk("t5_ready",   64'(bus.ready_o), 64'd0);
    tick();
    chk("t5_w1_data", bus.data_o, lanes(8'h68));
    chk("t5_w1_keep", 64'(bus.keep_o), 64'hFF);
    chk("t5_w1_last", 64'(bus.last_o), 64'd1);
    drive(8'h00, 64'h0, 1'b1);
    chk("t5_empty_rdy", 64'(bus.ready_o), 64'd1);
    tick();
    drive(8'h00, 64'h0, 1'b0);
    tick();
    chk("t5_empty_valid", 64'(bus.valid_o), 64'd1);
    chk("t5_empty_keep",  64'(bus.keep_o), 64'd0);
    chk("t5_empty_data",  bus.data_o, 64'd0);
    chk("t5_empty_last",  64'(bus.last_o), 64'd1);
    tick();

    // async reset with F=5 and a word held
    drive(8'hFF, lanes(8'h70), 1'b0);
    tick();
    drive(8'h1F, lanes(8'h78), 1'b0);
    bus.ready_i = 1'b0;
    tick();
    drive(8'h00, 64'h0, 1'b0);
    chk("t6_pre_valid", 64'(bus.valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.valid_o), 64'd0);
    chk("t6_rst_keep",  64'(bus.keep_o), 64'd0);
    chk("t6_rst_data",  bus.data_o, 64'd0);
    chk("t6_rst_last",  64'(bus.last_o), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    drive(8'h00, 64'h0, 1'b1);
    tick();
    drive(8'h00, 64'h0, 1'b0);
    tick();
    chk("t6_post_keep", 64'(bus.keep_o), 64'd0);
    chk("t6_post_last", 64'(bus.last_o), 64'd1);
    tick();

    // two lanes left idle
    drive(8'h03, 64'h0000000000003231, 1'b0);
    tick();
    drive(8'h00, 64'h0, 1'b0);
`ifdef STREAM_PACKER_TIMEOUT_EN
    for (int i = 0; i < 20 && !bus.valid_o; i++) tick();
    chk("to_seen", 64'(bus.valid_o), 64'd1);
    chk("to_keep", 64'(bus.keep_o), 64'h03);
    chk("to_data", bus.data_o, 64'h0000000000003231);
    chk("to_last", 64'(bus.last_o), 64'd0);
`else
    repeat (20) tick();
    chk("no_timeout", 64'(bus.valid_o), 64'd0);
    chk("no_timeout_rdy", 64'(bus.ready_o), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
